// File: rtl/hls_mem_model_if.sv
// ap_memory read port (in_r) and write port (out_r) bundled for the memory model.
// The master side is the HLS kernel, the slave side is the memory.
interface hls_mem_model_if #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned DATA_BITS = 32
);

  logic [ADDR_BITS-1:0]   in_r_address0;
  logic                   in_r_ce0;
  logic [DATA_BITS-1:0]   in_r_q0;
  logic [ADDR_BITS-1:0]   out_r_address0;
  logic                   out_r_ce0;
  logic                   out_r_we0;
  logic [DATA_BITS-1:0]   out_r_d0;
  logic [DATA_BITS/8-1:0] out_r_be0;

  modport master (
    output in_r_address0, in_r_ce0,
    output out_r_address0, out_r_ce0, out_r_we0, out_r_d0, out_r_be0,
    input  in_r_q0
  );

  modport slave (
    input  in_r_address0, in_r_ce0,
    input  out_r_address0, out_r_ce0, out_r_we0, out_r_d0, out_r_be0,
    output in_r_q0
  );

endinterface

// File: rtl/hls_mem_model.sv
// Behavioural shared-array memory behind one ap_memory read port and one write port.
// Read data is delayed by RD_LATENCY edges; writes are byte-masked; a registered debug
// peek port and saturating access counters expose state to the testbench.
module hls_mem_model #(
  parameter int unsigned          ADDR_BITS  = 6,
  parameter int unsigned          DATA_BITS  = 32,
  parameter int unsigned          RD_LATENCY = 1,
  parameter int unsigned          INIT_MODE  = 1,
  parameter logic [DATA_BITS-1:0] INIT_VALUE = '0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  hls_mem_model_if.slave       mem,
  input  logic                 init_req,
  input  logic [ADDR_BITS-1:0] dbg_address,
  output logic [DATA_BITS-1:0] dbg_q,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count
);

  localparam int unsigned Depth    = 2 ** ADDR_BITS;
  localparam int unsigned NumBytes = DATA_BITS / 8;

  function automatic logic [DATA_BITS-1:0] init_word(input int unsigned idx);
    if (INIT_MODE == 1) begin
      return DATA_BITS'(idx);
    end else if (INIT_MODE == 2) begin
      return INIT_VALUE;
    end
    return '0;
  endfunction

  logic [DATA_BITS-1:0] mem_q [Depth];
  logic [DATA_BITS-1:0] rd_q_q;
  logic [DATA_BITS-1:0] dbg_q_q;
  logic [15:0]          wr_count_q, wr_count_d;
  logic [15:0]          rd_count_q, rd_count_d;

  logic                 wr_acc;
  logic                 rd_acc;
  logic [DATA_BITS-1:0] rd_word;
  logic                 fin_v;
  logic [DATA_BITS-1:0] fin_d;

  // A write coinciding with a re-init request is dropped.
  assign wr_acc  = mem.out_r_ce0 & mem.out_r_we0 & ~init_req;
  assign rd_acc  = mem.in_r_ce0;
  // Array read sees pre-edge contents, giving read-before-write on collisions.
  assign rd_word = mem_q[mem.in_r_address0];

  // Storage array: init pattern on reset or init_req, byte-masked writes otherwise.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= init_word(i);
      end
    end else if (init_req) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= init_word(i);
      end
    end else if (wr_acc) begin
      for (int unsigned k = 0; k < NumBytes; k++) begin
        if (mem.out_r_be0[k]) begin
          mem_q[mem.out_r_address0][8*k +: 8] <= mem.out_r_d0[8*k +: 8];
        end
      end
    end
  end

  // Read pipeline: in_r_q0 itself is the last stage, so only RD_LATENCY-1 stages sit
  // ahead of it.
  if (RD_LATENCY == 1) begin : g_lat1
    assign fin_v = rd_acc;
    assign fin_d = rd_word;
  end else begin : g_pipe
    logic [RD_LATENCY-2:0] v_q;
    logic [DATA_BITS-1:0]  d_q [RD_LATENCY-1];

    // Shift (valid, data) pairs one stage per edge; reset discards reads in flight.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        v_q <= '0;
        for (int i = 0; i < int'(RD_LATENCY) - 1; i++) begin
          d_q[i] <= '0;
        end
      end else begin
        v_q[0] <= rd_acc;
        d_q[0] <= rd_word;
        for (int i = 1; i < int'(RD_LATENCY) - 1; i++) begin
          v_q[i] <= v_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end

    assign fin_v = v_q[RD_LATENCY-2];
    assign fin_d = d_q[RD_LATENCY-2];
  end

  // Output data register: updates only when a valid read completes, otherwise holds.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_q_q <= '0;
    end else if (fin_v) begin
      rd_q_q <= fin_d;
    end
  end

  // Debug peek: unconditional registered read of the array.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dbg_q_q <= '0;
    end else begin
      dbg_q_q <= mem_q[dbg_address];
    end
  end

  // Counter next state: saturating increments; init clears but still counts its own read.
  always_comb begin
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    if (init_req) begin
      wr_count_d = '0;
      rd_count_d = {15'd0, rd_acc};
    end else begin
      if (wr_acc && (wr_count_q != 16'hFFFF)) begin
        wr_count_d = wr_count_q + 16'd1;
      end
      if (rd_acc && (rd_count_q != 16'hFFFF)) begin
        rd_count_d = rd_count_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign mem.in_r_q0 = rd_q_q;
  assign dbg_q       = dbg_q_q;
  assign wr_count    = wr_count_q;
  assign rd_count    = rd_count_q;

endmodule

// File: doc/hls_mem_model.md
Name: hls_mem_model

Overview:
- Parametrised behavioural memory model for cocotb benches of HLS kernels.
- Serves one ap_memory read port (in_r) and one ap_memory write port (out_r), both backed by a single shared array, so kernel writes can be read back.
- Adds configurable read latency, byte enables, selectable init pattern, a debug readback port and access counters.
- Sits between the DUT's ap_memory ports and the Python testbench.

Parameters:
- ADDR_BITS, 6, address width; depth = 2^ADDR_BITS words.
- DATA_BITS, 32, word width; multiple of 8, range 8..128.
- RD_LATENCY, 1, cycles from in_r_ce0 sample to in_r_q0 update; legal 1..4.
- INIT_MODE, 1, array contents after reset/init: 0 = all zero, 1 = word i holds i (zero-extended), 2 = every word holds INIT_VALUE.
- INIT_VALUE, 0, constant used when INIT_MODE = 2.

Ports:
- ap_clk, in, 1, clock; all state updates on rising edge.
- ap_rst_n, in, 1, reset; asynchronous assert, active-low.
- in_r_address0, in, ADDR_BITS, read address.
- in_r_ce0, in, 1, read strobe.
- in_r_q0, out, DATA_BITS, read data.
- out_r_address0, in, ADDR_BITS, write address.
- out_r_ce0, in, 1, write port enable.
- out_r_we0, in, 1, write enable.
- out_r_d0, in, DATA_BITS, write data.
- out_r_be0, in, DATA_BITS/8, byte enables; bit k gates byte k.
- init_req, in, 1, synchronous one-cycle re-initialise request.
- dbg_address, in, ADDR_BITS, testbench peek address.
- dbg_q, out, DATA_BITS, registered peek data.
- wr_count, out, 16, number of accepted writes.
- rd_count, out, 16, number of accepted reads.

Behaviour:
- Reset (ap_rst_n = 0, async):
  - Array loaded per INIT_MODE.
  - in_r_q0, dbg_q, wr_count, rd_count = 0.
  - Read pipeline valid bits cleared; reads in flight are discarded.
- Write:
  - Accepted when out_r_ce0 & out_r_we0 are high at an edge.
  - Byte k of word[out_r_address0] <= out_r_d0 byte k when out_r_be0[k] = 1; other bytes keep their value.
  - All-zero be0 still counts as an accepted write.
  - out_r_ce0 without out_r_we0 is a no-op.
- Read:
  - Accepted when in_r_ce0 is high at an edge; the array is read at that edge.
  - Data goes through a RD_LATENCY-deep pipeline of (valid, data).
  - in_r_q0 updates exactly RD_LATENCY edges after acceptance.
  - in_r_q0 holds its last value when no valid read completes.
  - Back-to-back reads give one result per cycle.
- Read/write collision, same address, same edge: the read returns the old data (read-before-write). The new data is visible to reads accepted on the next edge.
- dbg_q <= word[dbg_address] every edge, 1-cycle latency, regardless of ce. Same read-before-write rule applies.
- Counters:
  - wr_count increments per accepted write; rd_count increments per accepted read.
  - Both saturate at 16'hFFFF (no wrap).
- init_req = 1 at an edge:
  - Array reloaded per INIT_MODE.
  - Counters cleared to 0.
  - A write on the same edge is dropped and not counted.
  - A read on the same edge is accepted, returns pre-init contents and counts as 1 after the clear (rd_count = 1).
  - Reads already in flight complete normally.
- Address wrap: addresses are exactly ADDR_BITS wide, so no out-of-range case exists.
- Reset asserted mid-operation overrides everything, including init_req.

Test Plan:
- Reset, INIT_MODE 1, RD_LATENCY 1; read addresses 0..63 back-to-back -> in_r_q0 = 0..63, each one edge after its ce; rd_count = 64.
- Write 0xDEADBEEF to addr 5 with be0 = 4'b1111, then 0x00001234 with be0 = 4'b0011; read 5 -> 0xDEAD1234; wr_count = 2.
- RD_LATENCY 3: read addr 7 at cycle t -> in_r_q0 = 7 at t+3, unchanged at t+1 and t+2; idle afterwards -> value held.
- Same-edge write 0xA5A5A5A5 and read at addr 9 -> read returns 9; next read of 9 -> 0xA5A5A5A5; dbg_address = 9 -> dbg_q = 0xA5A5A5A5 one edge later.
- Write 3 words, then init_req together with a write to addr 2 -> addr 2 reads 2, wr_count = 0; deassert ap_rst_n while a RD_LATENCY 2 read is in flight -> in_r_q0 = 0, no later update.
- Issue 70000 writes -> wr_count saturates at 0xFFFF and stays there.
